// File: rtl/rbm_0_top.sv
// RBM movie-rating inference engine: loads weights and per-user visible vectors over DMA,
// runs Gibbs passes, writes one rating per movie. Optional config check: RBM_CFG_CHECK_EN.
module rbm_0_top #(
  parameter int MAX_V = 64,
  parameter int MAX_H = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_done,
  input  logic [31:0] conf_num_hidden,
  input  logic [31:0] conf_num_loops,
  input  logic [31:0] conf_num_movies,
  input  logic [31:0] conf_num_testusers,
  input  logic [31:0] conf_num_users,
  input  logic [31:0] conf_num_visible,
  input  logic        rd_grant,
  input  logic        wr_grant,
  input  logic        data_in_valid,
  input  logic [31:0] data_in_data,
  output logic        data_in_ready,
  input  logic        data_out_ready,
  output logic [31:0] data_out_data,
  output logic        data_out_valid,
  output logic        done,
  output logic [31:0] rd_index,
  output logic [31:0] rd_length,
  output logic        rd_request,
  output logic [31:0] wr_index,
  output logic [31:0] wr_length,
  output logic        wr_request
);

  // state    | meaning
  // IDLE     | waiting for conf_done
  // LW_REQ   | weight read requested, waiting for grant
  // LW_DAT   | accepting V*H weight words
  // RV_REQ   | visible-vector read requested for current user
  // RV_DAT   | accepting V visible words
  // HMAC     | hidden pass: h_j = sum_i v_i*W[i][j] > 0
  // VMAC     | visible pass: s_i = sum_j h_j*W[i][j], v_i = s_i > 0
  // WR_REQ   | rating write requested, waiting for grant
  // WR_DAT   | streaming M ratings
  // ERR      | rejected configuration, one wait cycle
  // DONE     | one-cycle done pulse
  typedef enum logic [3:0] {
    S_IDLE, S_LW_REQ, S_LW_DAT, S_RV_REQ, S_RV_DAT,
    S_HMAC, S_VMAC, S_WR_REQ, S_WR_DAT, S_ERR, S_DONE
  } state_t;

  localparam int VW = $clog2(MAX_V);
  localparam int HW = $clog2(MAX_H);

  state_t state, state_n;

  logic [31:0] cfg_h, cfg_l, cfg_m, cfg_t, cfg_u, cfg_v;
  logic [31:0] eff_h, eff_v;
  logic [31:0] user_idx, users_left, loop_left, rem;
  logic [31:0] row, col, i_idx, j_idx, m_idx;
  logic signed [31:0] acc;
  logic [MAX_V-1:0] v_bits;
  logic [MAX_H-1:0] h_bits;
  logic signed [31:0] s_mem [MAX_V];
  logic signed [15:0] w_mem [MAX_V*MAX_H];
  logic signed [15:0] w_rd;
  logic [VW+HW-1:0] w_addr, ld_addr;
  logic [31:0] w_ext;
  logic xfer_in, xfer_out, cfg_bad;
  logic [31:0] r_base;
  logic signed [31:0] r_best;
  logic [2:0] rating;
  logic unused_data;

  assign unused_data = ^data_in_data[31:16];

`ifdef RBM_CFG_CHECK_EN
  assign cfg_bad = ({3'b0, conf_num_visible} != ({3'b0, conf_num_movies} * 35'd5)) ||
                   (conf_num_visible > 32'(MAX_V)) || (conf_num_hidden > 32'(MAX_H)) ||
                   (conf_num_hidden == 32'd0);
`else
  assign cfg_bad = 1'b0;
`endif

  // Compute loops are clamped to the storage size so bad configs cannot stall forever
  assign eff_h = (cfg_h > 32'(MAX_H)) ? 32'(MAX_H) : cfg_h;
  assign eff_v = (cfg_v > 32'(MAX_V)) ? 32'(MAX_V) : cfg_v;

  assign w_addr   = {i_idx[VW-1:0], j_idx[HW-1:0]};
  assign ld_addr  = {row[VW-1:0], col[HW-1:0]};
  assign w_rd     = w_mem[w_addr];
  assign w_ext    = {{16{w_rd[15]}}, w_rd};
  assign xfer_in  = data_in_valid && data_in_ready;
  assign xfer_out = data_out_valid && data_out_ready;

  always_comb begin
    r_base = m_idx * 32'd5;
    r_best = s_mem[VW'(r_base)];
    rating = 3'd0;
    for (int k = 1; k < 5; k++) begin
      if (s_mem[VW'(r_base + 32'(k))] > r_best) begin
        r_best = s_mem[VW'(r_base + 32'(k))];
        rating = 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n        = state;
    rd_request     = 1'b0;
    rd_index       = 32'd0;
    rd_length      = 32'd0;
    wr_request     = 1'b0;
    wr_index       = 32'd0;
    wr_length      = 32'd0;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    data_out_data  = 32'd0;
    done           = 1'b0;
    case (state)
      S_IDLE: if (conf_done) state_n = cfg_bad ? S_ERR : S_LW_REQ;
      S_LW_REQ: begin
        rd_request = 1'b1;
        rd_length  = cfg_v * cfg_h;
        if (rd_grant) state_n = S_LW_DAT;
      end
      S_LW_DAT: begin
        data_in_ready = (rem != 32'd0);
        if (rem == 32'd0) state_n = (cfg_t == 32'd0) ? S_DONE : S_RV_REQ;
      end
      S_RV_REQ: begin
        rd_request = 1'b1;
        rd_index   = cfg_v * cfg_h + (cfg_u + user_idx) * cfg_v;
        rd_length  = cfg_v;
        if (rd_grant) state_n = S_RV_DAT;
      end
      S_RV_DAT: begin
        data_in_ready = (rem != 32'd0);
        if (rem == 32'd0) state_n = S_HMAC;
      end
      S_HMAC: if (j_idx >= eff_h) state_n = S_VMAC;
      S_VMAC: if (i_idx >= eff_v) state_n = (loop_left <= 32'd1) ? S_WR_REQ : S_HMAC;
      S_WR_REQ: begin
        wr_request = 1'b1;
        wr_index   = user_idx * cfg_m;
        wr_length  = cfg_m;
        if (wr_grant) state_n = S_WR_DAT;
      end
      S_WR_DAT: begin
        data_out_valid = (rem != 32'd0);
        data_out_data  = {29'd0, rating};
        if (rem == 32'd0) state_n = (users_left <= 32'd1) ? S_DONE : S_RV_REQ;
      end
      S_ERR:  state_n = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && state == S_LW_DAT && xfer_in && row < 32'(MAX_V) && col < 32'(MAX_H))
      w_mem[ld_addr] <= data_in_data[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_h <= '0; cfg_l <= '0; cfg_m <= '0; cfg_t <= '0; cfg_u <= '0; cfg_v <= '0;
      user_idx <= '0; users_left <= '0; loop_left <= '0; rem <= '0;
      row <= '0; col <= '0; i_idx <= '0; j_idx <= '0; m_idx <= '0;
      acc <= '0;
    end else begin
      case (state)
        S_IDLE: if (conf_done) begin
          cfg_h <= conf_num_hidden;   cfg_l <= conf_num_loops;
          cfg_m <= conf_num_movies;   cfg_t <= conf_num_testusers;
          cfg_u <= conf_num_users;    cfg_v <= conf_num_visible;
          user_idx   <= '0;
          users_left <= conf_num_testusers;
        end
        S_LW_REQ: if (rd_grant) begin
          rem <= rd_length;
          row <= '0;
          col <= '0;
        end
        S_LW_DAT: if (xfer_in) begin
          rem <= rem - 32'd1;
          if (col + 32'd1 >= cfg_h) begin
            col <= '0;
            row <= row + 32'd1;
          end else begin
            col <= col + 32'd1;
          end
        end
        S_RV_REQ: if (rd_grant) begin
          rem   <= rd_length;
          i_idx <= '0;
        end
        S_RV_DAT: begin
          if (xfer_in) begin
            if (i_idx < 32'(MAX_V)) v_bits[i_idx[VW-1:0]] <= data_in_data[0];
            i_idx <= i_idx + 32'd1;
            rem   <= rem - 32'd1;
          end
          if (rem == 32'd0) begin
            i_idx     <= '0;
            j_idx     <= '0;
            acc       <= '0;
            loop_left <= (cfg_l == 32'd0) ? 32'd1 : cfg_l;
          end
        end
        S_HMAC: begin
          if (j_idx >= eff_h) begin
            i_idx <= '0; j_idx <= '0; acc <= '0;
          end else if (i_idx >= eff_v) begin
            h_bits[j_idx[HW-1:0]] <= (acc > 32'sd0);
            j_idx <= j_idx + 32'd1;
            i_idx <= '0;
            acc   <= '0;
          end else begin
            if (v_bits[i_idx[VW-1:0]]) acc <= acc + w_ext;
            i_idx <= i_idx + 32'd1;
          end
        end
        S_VMAC: begin
          if (i_idx >= eff_v) begin
            loop_left <= loop_left - 32'd1;
            i_idx <= '0; j_idx <= '0; acc <= '0;
          end else if (j_idx >= eff_h) begin
            s_mem[i_idx[VW-1:0]]  <= acc;
            v_bits[i_idx[VW-1:0]] <= (acc > 32'sd0);
            i_idx <= i_idx + 32'd1;
            j_idx <= '0;
            acc   <= '0;
          end else begin
            if (h_bits[j_idx[HW-1:0]]) acc <= acc + w_ext;
            j_idx <= j_idx + 32'd1;
          end
        end
        S_WR_REQ: if (wr_grant) begin
          rem   <= wr_length;
          m_idx <= '0;
        end
        S_WR_DAT: begin
          if (xfer_out) begin
            rem   <= rem - 32'd1;
            m_idx <= m_idx + 32'd1;
          end
          if (rem == 32'd0) begin
            user_idx   <= user_idx + 32'd1;
            users_left <= users_left - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_0_top.sv
// Directed bench for rbm_0_top: random grants/valid/ready around fixed weight patterns,
// ratings checked against hand-derived constants and a small software RBM.
module tb_rbm_0_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        conf_done;
  logic [31:0] conf_num_hidden, conf_num_loops, conf_num_movies;
  logic [31:0] conf_num_testusers, conf_num_users, conf_num_visible;
  logic        rd_grant, wr_grant;
  logic        data_in_valid;
  logic [31:0] data_in_data;
  logic        data_in_ready;
  logic        data_out_ready;
  logic [31:0] data_out_data;
  logic        data_out_valid;
  logic        done;
  logic [31:0] rd_index, rd_length, wr_index, wr_length;
  logic        rd_request, wr_request;

  always #5 clk = ~clk;

  rbm_0_top dut (
    .clk(clk), .rst(rst), .conf_done(conf_done),
    .conf_num_hidden(conf_num_hidden), .conf_num_loops(conf_num_loops),
    .conf_num_movies(conf_num_movies), .conf_num_testusers(conf_num_testusers),
    .conf_num_users(conf_num_users), .conf_num_visible(conf_num_visible),
    .rd_grant(rd_grant), .wr_grant(wr_grant),
    .data_in_valid(data_in_valid), .data_in_data(data_in_data), .data_in_ready(data_in_ready),
    .data_out_ready(data_out_ready), .data_out_data(data_out_data), .data_out_valid(data_out_valid),
    .done(done), .rd_index(rd_index), .rd_length(rd_length), .rd_request(rd_request),
    .wr_index(wr_index), .wr_length(wr_length), .wr_request(wr_request)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] idx;
    logic [31:0] len;
  } req_t;

  logic [31:0] mem [0:1023];
  req_t        req_q[$];
  logic [31:0] out_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rd_ptr;
  logic [31:0] held;
  logic        stalled;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          conf_cyc = 0;
  int          rd_req_seen = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // read side: random grant latency, spurious grants, random valid
  initial begin
    rd_grant = 0; data_in_valid = 0; data_in_data = 0; rd_ptr = 0;
    forever begin
      @(negedge clk);
      rd_grant = 0;
      if (rd_request) rd_req_seen++;
      if (rd_request && $urandom_range(0, 2) == 0) begin
        req_q.push_back({1'b0, rd_index, rd_length});
        rd_grant = 1;
        rd_ptr = rd_index;
      end else if (!rd_request && $urandom_range(0, 9) == 0) begin
        rd_grant = 1;
      end
      data_in_valid = 1'($urandom_range(0, 1));
      data_in_data = mem[rd_ptr[9:0]];
      if (data_in_valid && data_in_ready) rd_ptr++;
    end
  end

  // write side: random grants and ready; a stalled word must stay put
  initial begin
    wr_grant = 0; data_out_ready = 0; stalled = 0; held = 0;
    forever begin
      @(negedge clk);
      wr_grant = 0;
      if (stalled && rst) begin
        chk("wr_hold_valid", 32'(data_out_valid), 32'd1);
        chk("wr_hold_data", data_out_data, held);
      end
      if (wr_request && $urandom_range(0, 2) == 0) begin
        req_q.push_back({1'b1, wr_index, wr_length});
        wr_grant = 1;
      end else if (!wr_request && $urandom_range(0, 9) == 0) begin
        wr_grant = 1;
      end
      data_out_ready = 1'($urandom_range(0, 1));
      if (data_out_valid && data_out_ready) begin
        out_q.push_back(data_out_data);
        stalled = 0;
      end else begin
        stalled = data_out_valid;
        held = data_out_data;
      end
    end
  end

  function automatic int w_of(int h, int i, int j);
    logic [31:0] d;
    d = mem[i * h + j];
    return int'($signed(d[15:0]));
  endfunction

  function automatic void ref_user(int h, int l, int m, int v, int vbase);
    int vv[64];
    int hh[32];
    int s[64];
    int acc, best, bk;
    logic [31:0] d;
    for (int i = 0; i < v; i++) begin
      d = mem[vbase + i];
      vv[i] = int'(d[0]);
    end
    for (int p = 0; p < ((l == 0) ? 1 : l); p++) begin
      for (int j = 0; j < h; j++) begin
        acc = 0;
        for (int i = 0; i < v; i++) if (vv[i] != 0) acc += w_of(h, i, j);
        hh[j] = (acc > 0) ? 1 : 0;
      end
      for (int i = 0; i < v; i++) begin
        acc = 0;
        for (int j = 0; j < h; j++) if (hh[j] != 0) acc += w_of(h, i, j);
        s[i] = acc;
        vv[i] = (acc > 0) ? 1 : 0;
      end
    end
    for (int mm = 0; mm < m; mm++) begin
      best = s[5 * mm];
      bk = 0;
      for (int k = 1; k < 5; k++) if (s[5 * mm + k] > best) begin best = s[5 * mm + k]; bk = k; end
      exp_q.push_back(32'(bk));
    end
  endfunction

  task automatic clear();
    req_q.delete(); out_q.delete(); exp_q.delete();
    done_cnt = 0; rd_req_seen = 0;
  endtask

  task automatic start(input int h, input int l, input int m, input int t, input int u, input int v);
    @(negedge clk);
    conf_num_hidden = h; conf_num_loops = l; conf_num_movies = m;
    conf_num_testusers = t; conf_num_users = u; conf_num_visible = v;
    conf_done = 1;
    conf_cyc = cyc;
    @(negedge clk);
    conf_done = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (30) @(negedge clk);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic chk_outputs(input string tag);
    int n;
    n = (exp_q.size() < out_q.size()) ? exp_q.size() : out_q.size();
    chk({tag, "_word_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  task automatic load_pattern3();
    for (int i = 0; i < 25; i++)
      for (int j = 0; j < 10; j++)
        mem[i * 10 + j] = (i % 5 == 3) ? {16'h5a5a, 16'h0001} : {16'h0000, 16'hffff};
    for (int i = 0; i < 25; i++) mem[250 + i] = (i % 5 == 3) ? 32'hffff_fff1 : 32'hffff_fff0;
  endtask

  req_t exp_req[5];

  initial begin
    int wv, n;
    rst = 0; conf_done = 0;
    conf_num_hidden = 0; conf_num_loops = 0; conf_num_movies = 0;
    conf_num_testusers = 0; conf_num_users = 0; conf_num_visible = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({rd_request, wr_request, data_in_ready, data_out_valid, done}), 32'd0);
    chk("reset_rd_index", rd_index, 32'd0);
    chk("reset_data_out", data_out_data, 32'd0);
    rst = 1;
    repeat (2) @(negedge clk);

    // 1: H=10 L=2 M=5 T=2 U=2 V=25, random weights -8..8 with noise in the upper half
    clear();
    for (int k = 0; k < 250; k++) begin
      wv = int'($urandom_range(0, 16)) - 8;
      mem[k] = {16'($urandom), 16'(wv)};
    end
    for (int k = 250; k < 350; k++) mem[k] = $urandom;
    ref_user(10, 2, 5, 25, 300);
    ref_user(10, 2, 5, 25, 325);
    start(10, 2, 5, 2, 2, 25);
    wait_done("t1");
    exp_req[0] = {1'b0, 32'd0, 32'd250};
    exp_req[1] = {1'b0, 32'd300, 32'd25};
    exp_req[2] = {1'b1, 32'd0, 32'd5};
    exp_req[3] = {1'b0, 32'd325, 32'd25};
    exp_req[4] = {1'b1, 32'd5, 32'd5};
    chk("t1_req_count", 32'(req_q.size()), 32'd5);
    n = (req_q.size() < 5) ? req_q.size() : 5;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("t1_req%0d_wr", i), 32'(req_q[i].wr), 32'(exp_req[i].wr));
      chk($sformatf("t1_req%0d_idx", i), req_q[i].idx, exp_req[i].idx);
      chk($sformatf("t1_req%0d_len", i), req_q[i].len, exp_req[i].len);
    end
    chk_outputs("t1");

    // 2: zero weights, H=4 L=3 M=3 T=1 U=1 V=15 -> ratings all 0
    clear();
    for (int k = 0; k < 60; k++) mem[k] = {16'($urandom), 16'h0000};
    for (int k = 60; k < 90; k++) mem[k] = $urandom;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd0);
    start(4, 3, 3, 1, 1, 15);
    wait_done("t2");
    chk("t2_req_count", 32'(req_q.size()), 32'd3);
    if (req_q.size() >= 2) chk("t2_rdv_idx", req_q[1].idx, 32'd75);
    chk_outputs("t2");

    // 3: +1 on rows i%5==3, -1 elsewhere, v_i = (i%5==3), loops=0 -> ratings all 3
    clear();
    load_pattern3();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'd3);
    start(10, 0, 5, 1, 0, 25);
    wait_done("t3");
    chk_outputs("t3");

`ifdef RBM_CFG_CHECK_EN
    // 5: V != 5*M is rejected without touching the read channel
    clear();
    start(10, 1, 5, 1, 0, 24);
    wait_done("t5");
    chk("t5_rd_requests", 32'(rd_req_seen), 32'd0);
    chk("t5_done_latency", 32'(done_cyc - conf_cyc), 32'd2);
`endif

    // 6: reset during the visible read of user 0, then a clean restart
    clear();
    load_pattern3();
    start(10, 1, 5, 1, 0, 25);
    n = 0;
    while (req_q.size() < 2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_rdv", 32'(req_q.size()), 32'd2);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("t6_rst_ctrl", 32'({rd_request, wr_request, data_in_ready, data_out_valid, done}), 32'd0);
    chk("t6_rst_rd_index", rd_index, 32'd0);
    chk("t6_rst_rd_length", rd_length, 32'd0);
    chk("t6_rst_wr", wr_index | wr_length | data_out_data, 32'd0);
    @(negedge clk);
    rst = 1;
    clear();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'd3);
    start(10, 1, 5, 1, 0, 25);
    wait_done("t6");
    if (req_q.size() >= 1) begin
      chk("t6_first_idx", req_q[0].idx, 32'd0);
      chk("t6_first_len", req_q[0].len, 32'd250);
    end else begin
      chk("t6_first_req_present", 32'd0, 32'd1);
    end
    chk_outputs("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
